pixel_sink: RTL and testbench
=============================

Name: pixel_sink

Overview:
- Receiving end of the pixel plot stream that paddle-style renderers emit: oX, oY, oColour, oPlot, oNewFrame.
- Range-checks each plotted pixel and converts it to a linear frame-buffer address.
- Buffers pixels in a small FIFO and writes them to video memory over a valid/ready write port.
- Sits between the game object renderers and the frame-buffer RAM / VGA adapter.

Parameters:
- X_SCREEN_PIXELS, 320: screen width; XW = $clog2(X_SCREEN_PIXELS)+1 input x bits.
- Y_SCREEN_PIXELS, 240: screen height; YW = $clog2(Y_SCREEN_PIXELS)+1 input y bits.
- FIFO_DEPTH, 8: pixel FIFO entries; must be a power of 2, at least 2.
- AW, $clog2(X_SCREEN_PIXELS*Y_SCREEN_PIXELS): memory address width (17 at defaults).

Ports:
- iClock  in  1  system clock, single clock domain.
- iReset  in  1  synchronous, active-high reset.
- iX  in  XW  pixel x coordinate.
- iY  in  YW  pixel y coordinate.
- iColour  in  3  pixel colour (0-7).
- iPlot  in  1  pixel valid; one pixel per cycle while high; no backpressure to the producer.
- iNewFrame  in  1  single-cycle frame-complete pulse from the renderer.
- oMemAddr  out  AW  write address, equal to y*X_SCREEN_PIXELS + x.
- oMemData  out  3  write colour.
- oMemWe  out  1  write valid.
- iMemReady  in  1  memory accepts the write on a cycle where oMemWe && iMemReady.
- oEmpty  out  1  FIFO empty and no write pending.
- oFull  out  1  FIFO holds FIFO_DEPTH entries.
- oOverflow  out  1  sticky: a pixel was lost because the FIFO was full.
- oClipped  out  1  one-cycle pulse: an out-of-range pixel was discarded.
- oFrameCount  out  8  count of iNewFrame pulses, wraps 255 to 0.

Behaviour:
- Reset (iReset sampled high at an edge):
  - oMemAddr=0, oMemData=0, oMemWe=0, oFull=0, oOverflow=0, oClipped=0, oFrameCount=0, oEmpty=1.
  - FIFO pointers and count cleared; the input stage register is invalidated.
  - Reset mid-write abandons the pending write; oMemWe is 0 in the first cycle after the reset edge.
- Stage 1, input register: on each edge with iPlot=1:
  - Range check: x < X_SCREEN_PIXELS and y < Y_SCREEN_PIXELS.
  - In range: register addr = y*X_SCREEN_PIXELS + x (unsigned, AW bits, no truncation for legal inputs) plus colour, and set stage valid.
  - Out of range: oClipped=1 for the next cycle, stage valid=0, pixel discarded.
  - iPlot=0 gives stage valid=0.
- Stage 2, FIFO push when stage valid:
  - If count < FIFO_DEPTH, or a pop occurs in the same cycle, the entry is written.
  - Otherwise the entry is dropped and oOverflow set; it stays set until reset.
- Write FSM:
  - S_IDLE: oMemWe=0. If FIFO non-empty, load the head into oMemAddr/oMemData, pop it, and go to S_WRITE.
  - S_WRITE: oMemWe=1; oMemAddr and oMemData held stable until iMemReady=1 is sampled.
  - On acceptance, if the FIFO is non-empty: load the next head and pop it; stay in S_WRITE (back-to-back, one write per cycle with iMemReady tied high).
  - On acceptance with the FIFO empty: go to S_IDLE.
- Latency: iPlot at edge N, FIFO entry at edge N+1, oMemWe=1 after edge N+2 (empty FIFO, FSM idle).
- Status outputs:
  - Count, oFull and oEmpty are registered and reflect the post-edge state.
  - oEmpty = (count==0) && state==S_IDLE && !stage valid.
  - Simultaneous push and pop leaves count unchanged; push while full with no pop is the drop case.
- Pointers wrap modulo FIFO_DEPTH.
- oFrameCount increments on each edge with iNewFrame=1, independent of pixel traffic.
- Pixel ordering is preserved exactly; no coalescing of repeated addresses.

Optional Feature:
- Macro PIXEL_SINK_DROPCNT_EN.
- Defined: adds output oDropCount (16 bits, reset 0), incremented once per FIFO-full drop and once per clipped pixel. It saturates at 65535 and does not wrap.
- Undefined: the port and counter are absent; oOverflow and oClipped are the only loss indication.

Test Plan:
- Reset, then plot (x=10,y=5,c=7) with iMemReady=1 -> oMemWe=1 two cycles later with oMemAddr=1610, oMemData=7 for exactly one cycle; oEmpty returns to 1.
- iMemReady=0; plot 9 consecutive in-range pixels -> oFull=1 after 8 entries. Released, the 10th pixel is dropped, oOverflow=1; then raise iMemReady -> exactly 9 writes in input order.
- Plot (320,0) and (0,240) -> oClipped pulses twice, no oMemWe, oEmpty stays 1; with PIXEL_SINK_DROPCNT_EN, oDropCount=2.
- Hold iMemReady=0 for 5 cycles during a write -> oMemAddr/oMemData unchanged across all 5 cycles; single acceptance when iMemReady rises.
- 300 iNewFrame pulses -> oFrameCount=44.
- Assert iReset while 4 entries are queued and oMemWe=1 -> next cycle oMemWe=0, oEmpty=1, oOverflow=0; no further writes occur.

Source files
------------

// File: rtl/pixel_sink.sv
// Pixel plot sink: range-checks plotted pixels, converts them to linear frame-buffer
// addresses, queues them in a FIFO and writes them out over a valid/ready port.
// Optional build macro PIXEL_SINK_DROPCNT_EN adds the 16-bit saturating oDropCount output.
module pixel_sink #(
  parameter int X_SCREEN_PIXELS = 320,
  parameter int Y_SCREEN_PIXELS = 240,
  parameter int FIFO_DEPTH      = 8,
  parameter int XW              = $clog2(X_SCREEN_PIXELS) + 1,
  parameter int YW              = $clog2(Y_SCREEN_PIXELS) + 1,
  parameter int AW              = $clog2(X_SCREEN_PIXELS * Y_SCREEN_PIXELS)
) (
  input  logic          iClock,
  input  logic          iReset,
  input  logic [XW-1:0] iX,
  input  logic [YW-1:0] iY,
  input  logic [2:0]    iColour,
  input  logic          iPlot,
  input  logic          iNewFrame,
  output logic [AW-1:0] oMemAddr,
  output logic [2:0]    oMemData,
  output logic          oMemWe,
  input  logic          iMemReady,
  output logic          oEmpty,
  output logic          oFull,
  output logic          oOverflow,
  output logic          oClipped,
  output logic [7:0]    oFrameCount
`ifdef PIXEL_SINK_DROPCNT_EN
  ,
  output logic [15:0]   oDropCount
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = AW + 3;
  localparam logic [XW-1:0] X_LIMIT = XW'(X_SCREEN_PIXELS);
  localparam logic [YW-1:0] Y_LIMIT = YW'(Y_SCREEN_PIXELS);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic {
    S_IDLE,
    S_WRITE
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic          w_in_range;
  logic          w_clip_now;
  logic [AW-1:0] w_addr;
  logic          r_stage_valid;
  logic [AW-1:0] r_stage_addr;
  logic [2:0]    r_stage_colour;
  logic          r_clipped;

  logic [EW-1:0] r_fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [EW-1:0] w_head;
  logic          w_push;
  logic          w_pop;
  logic          w_drop;
  logic          w_fifo_nonempty;

  logic [AW-1:0] r_mem_addr;
  logic [2:0]    r_mem_data;
  logic          r_overflow;
  logic [7:0]    r_frame_count;

  // Stage 1: range check and linear address.
  assign w_in_range = (iX < X_LIMIT) && (iY < Y_LIMIT);
  assign w_clip_now = iPlot && !w_in_range;
  assign w_addr     = AW'(iY) * AW'(X_SCREEN_PIXELS) + AW'(iX);

  always_ff @(posedge iClock) begin
    if (iReset) begin
      r_stage_valid  <= 1'b0;
      r_stage_addr   <= '0;
      r_stage_colour <= '0;
      r_clipped      <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      r_stage_valid <= iPlot && w_in_range;
      r_clipped     <= w_clip_now;
      if (iPlot && w_in_range) begin
        r_stage_addr   <= w_addr;
        r_stage_colour <= iColour;
      end
    end
  end

  // Stage 2: FIFO. A pop in the same cycle frees a slot for a push into a full FIFO.
  assign w_fifo_nonempty = (r_count != '0);
  assign w_push          = r_stage_valid && ((r_count < DEPTH_C) || w_pop);
  assign w_drop          = r_stage_valid && !w_push;
  assign w_head          = r_fifo_mem[r_rd_ptr];

  // NOTE: the storage array has no reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge iClock) begin
    if (w_push) begin
      r_fifo_mem[r_wr_ptr] <= {r_stage_addr, r_stage_colour};
    end
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Write FSM: the output register holds the popped head until the memory accepts it.
  always_ff @(posedge iClock) begin
    if (iReset) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    oMemWe       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_fifo_nonempty) begin
          w_pop        = 1'b1;
          w_next_state = S_WRITE;
        end
      end
      S_WRITE: begin
        oMemWe = 1'b1;
        if (iMemReady) begin
          if (w_fifo_nonempty) w_pop        = 1'b1;
          else                 w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      r_mem_addr <= '0;
      r_mem_data <= '0;
    end else if (w_pop) begin
      {r_mem_addr, r_mem_data} <= w_head;
    end
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      r_overflow    <= 1'b0;
      r_frame_count <= '0;
    end else begin
      if (w_drop)    r_overflow    <= 1'b1;
      if (iNewFrame) r_frame_count <= r_frame_count + 8'd1;
    end
  end

  assign oMemAddr    = r_mem_addr;
  assign oMemData    = r_mem_data;
  assign oFull       = (r_count == DEPTH_C);
  assign oEmpty      = (r_count == '0) && (r_state == S_IDLE) && !r_stage_valid;
  assign oOverflow   = r_overflow;
  assign oClipped    = r_clipped;
  assign oFrameCount = r_frame_count;

`ifdef PIXEL_SINK_DROPCNT_EN
  // A clip and a FIFO drop can land on the same edge, so the increment is 0..2.
  logic [15:0] r_drop_count;
  logic [15:0] w_loss;

  assign w_loss = 16'(w_drop) + 16'(w_clip_now);

  always_ff @(posedge iClock) begin
    if (iReset) begin
      r_drop_count <= '0;
    end else if (r_drop_count > (16'hFFFF - w_loss)) begin
      r_drop_count <= 16'hFFFF;
    end else begin
      r_drop_count <= r_drop_count + w_loss;
    end
  end

  assign oDropCount = r_drop_count;
`else
  // Without the counter, losses are visible only through oOverflow and oClipped.
`endif

endmodule

// File: tb/tb_pixel_sink.sv
// Scoreboard bench for pixel_sink: stimulus pushes expected writes into a queue and a
// negedge monitor pops and compares on every accepted write.
module tb_pixel_sink;

  localparam int XS    = 320;
  localparam int YS    = 240;
  localparam int XW    = 10;
  localparam int YW    = 9;
  localparam int AW    = 17;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [2:0]    data;
  } wr_t;

  logic          iClock;
  logic          iReset;
  logic [XW-1:0] iX;
  logic [YW-1:0] iY;
  logic [2:0]    iColour;
  logic          iPlot;
  logic          iNewFrame;
  logic [AW-1:0] oMemAddr;
  logic [2:0]    oMemData;
  logic          oMemWe;
  logic          iMemReady;
  logic          oEmpty;
  logic          oFull;
  logic          oOverflow;
  logic          oClipped;
  logic [7:0]    oFrameCount;
`ifdef PIXEL_SINK_DROPCNT_EN
  logic [15:0]   oDropCount;
`endif

  pixel_sink dut (
    .iClock      (iClock),
    .iReset      (iReset),
    .iX          (iX),
    .iY          (iY),
    .iColour     (iColour),
    .iPlot       (iPlot),
    .iNewFrame   (iNewFrame),
    .oMemAddr    (oMemAddr),
    .oMemData    (oMemData),
    .oMemWe      (oMemWe),
    .iMemReady   (iMemReady),
    .oEmpty      (oEmpty),
    .oFull       (oFull),
    .oOverflow   (oOverflow),
    .oClipped    (oClipped),
    .oFrameCount (oFrameCount)
`ifdef PIXEL_SINK_DROPCNT_EN
    ,
    .oDropCount  (oDropCount)
`endif
  );

  initial iClock = 1'b0;
  always #5 iClock = ~iClock;

  wr_t exp_q[$];
  int  checks     = 0;
  int  errors     = 0;
  int  n_writes   = 0;
  int  clips_seen = 0;
  int  exp_clips  = 0;
  int  exp_drops  = 0;
  int  ready_mode = 1;   // 0 = low, 1 = high, 2 = random per cycle

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: scoreboard compare on acceptance, stability check across stalled cycles.
  logic          prev_stall = 1'b0;
  logic [AW-1:0] prev_addr;
  logic [2:0]    prev_data;
  wr_t           mon_e;

  always @(negedge iClock) begin
    if (iReset === 1'b1) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && oMemWe === 1'b1) begin
        check("stall_addr_stable", 32'(oMemAddr), 32'(prev_addr));
        check("stall_data_stable", 32'(oMemData), 32'(prev_data));
      end
      if (oMemWe === 1'b1 && iMemReady === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got addr %0d data %0d, expected no write", oMemAddr, oMemData);
        end else begin
          mon_e = exp_q.pop_front();
          if (oMemAddr !== mon_e.addr || oMemData !== mon_e.data) begin
            errors++;
            $display("FAIL write: got addr %0d data %0d, expected addr %0d data %0d",
                     oMemAddr, oMemData, mon_e.addr, mon_e.data);
          end
        end
        n_writes++;
      end
      prev_stall = (oMemWe === 1'b1) && (iMemReady !== 1'b1);
      prev_addr  = oMemAddr;
      prev_data  = oMemData;
      if (oClipped === 1'b1) clips_seen++;
    end
  end

  task automatic set_ready(input int mode);
    ready_mode = mode;
    if (mode == 0) iMemReady = 1'b0;
    else if (mode == 1) iMemReady = 1'b1;
  endtask

  task automatic step();
    @(posedge iClock);
    #1;
    case (ready_mode)
      0:       iMemReady = 1'b0;
      1:       iMemReady = 1'b1;
      default: iMemReady = ($urandom_range(0, 1) != 0);
    endcase
  endtask

  // Model: in-range pixels become writes of y*XS+x in order; others are clipped.
  task automatic plot(input int x, input int y, input int c, input bit expect_drop);
    wr_t w;
    iX      = XW'(x);
    iY      = YW'(y);
    iColour = 3'(c);
    iPlot   = 1'b1;
    if (x < XS && y < YS) begin
      if (expect_drop) begin
        exp_drops++;
      end else begin
        w.addr = AW'(y * XS + x);
        w.data = 3'(c);
        exp_q.push_back(w);
      end
    end else begin
      exp_clips++;
      exp_drops++;
    end
    step();
    iPlot = 1'b0;
  endtask

  task automatic wait_empty(input int budget, input string name);
    int n = 0;
    @(negedge iClock);
    while (oEmpty !== 1'b1 && n < budget) begin
      step();
      @(negedge iClock);
      n++;
    end
    checks++;
    if (oEmpty !== 1'b1) begin
      errors++;
      $display("FAIL %s: oEmpty still %0b after %0d cycles, expected 1", name, oEmpty, budget);
    end
  endtask

  task automatic apply_reset();
    iReset    = 1'b1;
    iPlot     = 1'b0;
    iNewFrame = 1'b0;
    exp_q.delete();
    exp_drops = 0;
    step();
    iReset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int wb;
    int n;
    iReset = 1'b1; iPlot = 1'b0; iX = '0; iY = '0; iColour = '0;
    iNewFrame = 1'b0; iMemReady = 1'b1; ready_mode = 1;
    step();
    apply_reset();

    // Reset state
    @(negedge iClock);
    check("rst_we",      32'(oMemWe), 0);
    check("rst_addr",    32'(oMemAddr), 0);
    check("rst_data",    32'(oMemData), 0);
    check("rst_empty",   32'(oEmpty), 1);
    check("rst_full",    32'(oFull), 0);
    check("rst_ovf",     32'(oOverflow), 0);
    check("rst_clip",    32'(oClipped), 0);
    check("rst_frames",  32'(oFrameCount), 0);

    // Single pixel latency: write visible after the second edge following the plot
    set_ready(1);
    plot(10, 5, 7, 0);
    @(negedge iClock); check("lat_we_n0", 32'(oMemWe), 0);
    step(); @(negedge iClock); check("lat_we_n1", 32'(oMemWe), 0);
    step(); @(negedge iClock);
    check("lat_we_n2",   32'(oMemWe), 1);
    check("lat_addr_n2", 32'(oMemAddr), 1610);
    check("lat_data_n2", 32'(oMemData), 7);
    step(); @(negedge iClock);
    check("lat_we_n3",    32'(oMemWe), 0);
    check("lat_empty_n3", 32'(oEmpty), 1);

    // Fill with memory stalled: 9 held, 10th dropped, then 9 ordered writes
    set_ready(0);
    for (int i = 0; i < 9; i++) plot(i * 7, i * 3 + 1, i % 8, 0);
    step(); step(); @(negedge iClock);
    check("fill_full", 32'(oFull), 1);
    check("fill_ovf",  32'(oOverflow), 0);
    plot(100, 100, 3, 1);
    step(); step(); @(negedge iClock);
    check("drop_ovf",  32'(oOverflow), 1);
    check("drop_full", 32'(oFull), 1);
    wb = n_writes;
    set_ready(1);
    wait_empty(50, "fill_drain");
    check("fill_writes",  32'(n_writes - wb), 9);
    check("fill_q_empty", 32'(exp_q.size()), 0);

    // Clipping at both boundaries, then the last legal pixel
    wb = n_writes;
    plot(320, 0, 1, 0);
    @(negedge iClock);
    check("clip_x_pulse", 32'(oClipped), 1);
    check("clip_x_empty", 32'(oEmpty), 1);
    plot(0, 240, 2, 0);
    @(negedge iClock);
    check("clip_y_pulse", 32'(oClipped), 1);
    step(); @(negedge iClock);
    check("clip_end",      32'(oClipped), 0);
    check("clip_empty",    32'(oEmpty), 1);
    check("clip_no_write", 32'(n_writes - wb), 0);
`ifdef PIXEL_SINK_DROPCNT_EN
    check("dropcnt_clip", 32'(oDropCount), 32'(exp_drops));
`endif
    plot(319, 239, 6, 0);
    wait_empty(20, "corner_drain");

    // Stall for 5 cycles mid-write, then a single acceptance
    wb = n_writes;
    set_ready(0);
    plot(123, 45, 5, 0);
    n = 0;
    @(negedge iClock);
    while (oMemWe !== 1'b1 && n < 10) begin step(); @(negedge iClock); n++; end
    check("stall_we_seen", 32'(oMemWe), 1);
    for (int i = 0; i < 5; i++) begin
      step(); @(negedge iClock);
      check("stall_hold_addr", 32'(oMemAddr), 45 * 320 + 123);
      check("stall_hold_data", 32'(oMemData), 5);
    end
    set_ready(1);
    wait_empty(20, "stall_drain");
    check("stall_one_write", 32'(n_writes - wb), 1);

    // Frame counter wraps modulo 256
    for (int i = 0; i < 300; i++) begin
      iNewFrame = 1'b1;
      step();
      iNewFrame = 1'b0;
      if ($urandom_range(0, 1) != 0) step();
    end
    @(negedge iClock);
    check("frames_300", 32'(oFrameCount), 300 % 256);

    // Reset with a write pending and 4 entries queued abandons everything
    set_ready(0);
    for (int i = 0; i < 5; i++) plot(200 + i, 100, i + 1, 0);
    step(); step(); step(); @(negedge iClock);
    check("pre_rst_we", 32'(oMemWe), 1);
    apply_reset();
    @(negedge iClock);
    check("post_rst_we",     32'(oMemWe), 0);
    check("post_rst_empty",  32'(oEmpty), 1);
    check("post_rst_ovf",    32'(oOverflow), 0);
    check("post_rst_frames", 32'(oFrameCount), 0);
    wb = n_writes;
    set_ready(1);
    for (int i = 0; i < 20; i++) step();
    check("post_rst_no_writes", 32'(n_writes - wb), 0);

    // Randomized bursts of at most 9 in-range pixels, random memory readiness
    set_ready(2);
    for (int b = 0; b < 25; b++) begin
      int inr = 0;
      int cyc = 0;
      while (inr < 9 && cyc < 30) begin
        if ($urandom_range(0, 3) != 0) begin
          int x = int'($urandom_range(0, 340));
          int y = int'($urandom_range(0, 260));
          if (x < XS && y < YS) inr++;
          plot(x, y, int'($urandom_range(0, 7)), 0);
        end else begin
          step();
        end
        cyc++;
      end
      wait_empty(300, "burst_drain");
    end
    set_ready(1);
    step(); @(negedge iClock);
    check("rand_q_empty", 32'(exp_q.size()), 0);
    check("rand_ovf",     32'(oOverflow), 0);
    check("clip_count",   32'(clips_seen), 32'(exp_clips));
`ifdef PIXEL_SINK_DROPCNT_EN
    check("dropcnt_final", 32'(oDropCount), 32'(exp_drops));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
